// File: rtl/snake_pkg.sv
// snake_pkg
//   Shared encodings and grid geometry for the snake game controller.
//   dir_t   : movement direction (0 up, 1 right, 2 down, 3 left)
//   state_t : game state (0 idle, 1 run, 2 pause, 3 stop)
//   GRID_W/GRID_H : playfield size in cells; CELL_SHIFT : log2 of cell size in pixels
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int GRID_W     = 80;
    localparam int GRID_H     = 60;
    localparam int CELL_SHIFT = 3;

    // Up/down and left/right differ only in bit 1.
    function automatic dir_t dir_opposite(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/snake_body_buf.sv
// snake_body_buf
//   Segment shift buffer plus the two comparators that look at it:
//   pixel hit (is this cell part of the visible body) and head hit
//   (would the proposed new head land on the body).
// Ports:
//   clk25MHz          clock
//   init              load the start body: segment i at (GRID_W/2-i, GRID_H/2)
//   shift             push new head, every segment takes its predecessor's cell
//   new_x/new_y       proposed head cell
//   len               current segment count
//   keep_tail         tail stays on the next step, so it counts as an obstacle
//   pix_x/pix_y       cell of the pixel being drawn
//   pix_hit           pixel cell matches one of the first len segments
//   head_hit          proposed head collides with the body
//   head_x/head_y     current head cell
module snake_body_buf
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic       clk25MHz,
    input  logic       init,
    input  logic       shift,
    input  logic [6:0] new_x,
    input  logic [5:0] new_y,
    input  logic [4:0] len,
    input  logic       keep_tail,
    input  logic [6:0] pix_x,
    input  logic [5:0] pix_y,
    output logic       pix_hit,
    output logic       head_hit,
    output logic [6:0] head_x,
    output logic [5:0] head_y
);

    logic [6:0] seg_x [MAX_LEN];
    logic [5:0] seg_y [MAX_LEN];

    always_ff @(posedge clk25MHz) begin
        if (init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= 7'(GRID_W / 2 - i);
                seg_y[i] <= 6'(GRID_H / 2);
            end
        end else if (shift) begin
            seg_x[0] <= new_x;
            seg_y[0] <= new_y;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
            end
        end
    end

    always_comb begin
        pix_hit  = 1'b0;
        head_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len) && seg_x[i] == pix_x && seg_y[i] == pix_y)
                pix_hit = 1'b1;
            // The tail vacates its cell on a normal step, so only a growing
            // step treats it as an obstacle.
            if ((keep_tail ? (i < int'(len)) : (i < int'(len) - 1)) &&
                seg_x[i] == new_x && seg_y[i] == new_y)
                head_hit = 1'b1;
        end
    end

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
//   Snake game controller: game FSM, frame divider, direction filter and
//   registered pixel outputs. Body storage lives in snake_body_buf.
// Ports:
//   clk25MHz, rst          pixel clock, synchronous active-high reset
//   hcount, vcount         current pixel position
//   frame_start            one-cycle pulse at the start of each frame
//   dir_req, dir_valid     requested direction and its qualifier
//   start, pause, grow     control pulses
//   Snake                  pixel belongs to the body (1 cycle latency)
//   Black                  blank screen (idle)
//   state, length          game state and segment count
// Build option:
//   SNAKE_WRAP_EN          head wraps at grid edges instead of stopping the game
//
// state    | meaning
// ST_IDLE  | waiting for start, screen blank
// ST_RUN   | counting frames, stepping every MOVE_DIV frames
// ST_PAUSE | frozen, pause resumes
// ST_STOP  | collision or wall hit, body shown, start restarts
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4,
    parameter int MOVE_DIV = 8
) (
    input  logic        clk25MHz,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        frame_start,
    input  logic [1:0]  dir_req,
    input  logic        dir_valid,
    input  logic        start,
    input  logic        pause,
    input  logic        grow,
    output logic        Snake,
    output logic        Black,
    output logic [1:0]  state,
    output logic [4:0]  length
);

    localparam int FW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    state_t      st, st_nxt;
    logic [FW-1:0] fcnt;
    // The committed direction always equals pending_dir at the moment of a
    // step, so a single register carries both.
    dir_t        pending_dir;
    logic        grow_flag;
    logic        do_step, do_restart, frame_tick;
    logic        off_grid, edge_stop;
    logic [6:0]  new_x, head_x;
    logic [5:0]  new_y, head_y;
    logic        pix_hit, head_hit;

    snake_body_buf #(.MAX_LEN(MAX_LEN)) u_body (
        .clk25MHz (clk25MHz),
        .init     (rst | do_restart),
        .shift    (do_step),
        .new_x    (new_x),
        .new_y    (new_y),
        .len      (length),
        .keep_tail(grow_flag),
        .pix_x    (hcount[CELL_SHIFT+6:CELL_SHIFT]),
        .pix_y    (vcount[CELL_SHIFT+5:CELL_SHIFT]),
        .pix_hit  (pix_hit),
        .head_hit (head_hit),
        .head_x   (head_x),
        .head_y   (head_y)
    );

    assign frame_tick = frame_start && (fcnt == FW'(MOVE_DIV - 1));

    // Proposed head; new_x/new_y already hold the wrapped cell at the edges.
    always_comb begin
        new_x    = head_x;
        new_y    = head_y;
        off_grid = 1'b0;
        case (pending_dir)
            DIR_UP:    if (head_y == 6'd0) begin
                           off_grid = 1'b1;
                           new_y    = 6'(GRID_H - 1);
                       end else new_y = head_y - 6'd1;
            DIR_RIGHT: if (head_x == 7'(GRID_W - 1)) begin
                           off_grid = 1'b1;
                           new_x    = 7'd0;
                       end else new_x = head_x + 7'd1;
            DIR_DOWN:  if (head_y == 6'(GRID_H - 1)) begin
                           off_grid = 1'b1;
                           new_y    = 6'd0;
                       end else new_y = head_y + 6'd1;
            default:   if (head_x == 7'd0) begin
                           off_grid = 1'b1;
                           new_x    = 7'(GRID_W - 1);
                       end else new_x = head_x - 7'd1;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign edge_stop = 1'b0;
    logic unused_off_grid;
    assign unused_off_grid = off_grid;
`else
    assign edge_stop = off_grid;
`endif

    always_comb begin
        st_nxt     = st;
        do_step    = 1'b0;
        do_restart = 1'b0;
        case (st)
            ST_IDLE, ST_STOP: if (start) begin
                st_nxt     = ST_RUN;
                do_restart = 1'b1;
            end
            ST_RUN: if (pause) begin
                st_nxt = ST_PAUSE;
            end else if (frame_tick) begin
                if (edge_stop || head_hit) st_nxt  = ST_STOP;
                else                       do_step = 1'b1;
            end
            default: if (pause) st_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            st          <= ST_IDLE;
            fcnt        <= '0;
            pending_dir <= DIR_RIGHT;
            grow_flag   <= 1'b0;
            length      <= 5'(INIT_LEN);
            Snake       <= 1'b0;
            Black       <= 1'b1;
        end else begin
            st    <= st_nxt;
            Snake <= (st != ST_IDLE) && (hcount < 11'd640) && (vcount < 11'd480) && pix_hit;
            Black <= (st == ST_IDLE);
            if (do_restart) begin
                fcnt        <= '0;
                pending_dir <= DIR_RIGHT;
                grow_flag   <= 1'b0;
                length      <= 5'(INIT_LEN);
            end else begin
                if (st == ST_RUN && !pause && frame_start)
                    fcnt <= frame_tick ? '0 : fcnt + 1'b1;
                if (dir_valid && (st == ST_RUN || st == ST_PAUSE) &&
                    dir_t'(dir_req) != dir_opposite(pending_dir))
                    pending_dir <= dir_t'(dir_req);
                if (do_step) begin
                    if (grow_flag && length < 5'(MAX_LEN))
                        length <= length + 5'd1;
                    grow_flag <= 1'b0;
                end
                // A grow arriving on a step cycle applies to the following step.
                if (grow && (st == ST_RUN || st == ST_PAUSE))
                    grow_flag <= 1'b1;
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;

    logic        clk25MHz = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount = '0;
    logic [10:0] vcount = '0;
    logic        frame_start = 1'b0;
    logic [1:0]  dir_req = '0;
    logic        dir_valid = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        grow = 1'b0;
    logic        Snake, Black;
    logic [1:0]  state;
    logic [4:0]  length;

    int n_cmp = 0;
    int n_fail = 0;

    always #20 clk25MHz = ~clk25MHz;

    snake_game_ctrl #(.MAX_LEN(16), .INIT_LEN(4), .MOVE_DIV(8)) dut (
        .clk25MHz   (clk25MHz),
        .rst        (rst),
        .hcount     (hcount),
        .vcount     (vcount),
        .frame_start(frame_start),
        .dir_req    (dir_req),
        .dir_valid  (dir_valid),
        .start      (start),
        .pause      (pause),
        .grow       (grow),
        .Snake      (Snake),
        .Black      (Black),
        .state      (state),
        .length     (length)
    );

    task automatic tick();
        @(posedge clk25MHz);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    // Returns Snake for the centre pixel of cell (cx,cy).
    task automatic probe(input int cx, input int cy, output logic s);
        hcount = 11'(cx * 8 + 4);
        vcount = 11'(cy * 8 + 4);
        tick();
        s = Snake;
    endtask

    task automatic send_dir(input logic [1:0] d);
        dir_req = d;
        dir_valid = 1'b1;
        tick();
        dir_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        tick();
        pause = 1'b0;
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        tick();
        grow = 1'b0;
    endtask

    task automatic test_reset();
        logic s;
        int bad;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (length !== 5'd4) begin n_fail++; $display("FAIL reset_length: got %0d want 4", length); end
        n_cmp++; if (Black !== 1'b1) begin n_fail++; $display("FAIL reset_black: got %b want 1", Black); end
        bad = 0;
        for (int y = 0; y < 60; y++)
            for (int x = 0; x < 80; x++) begin
                probe(x, y, s);
                if (s !== 1'b0) bad++;
            end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL reset_scan: %0d cells with Snake=1, want 0", bad); end
        n_cmp++; if (Black !== 1'b1) begin n_fail++; $display("FAIL reset_black_scan: got %b want 1", Black); end
    endtask

    task automatic test_idle_ignores();
        pulse_pause();
        pulse_grow();
        send_dir(2'd2);
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_ignore: state %0d want 0", state); end
        start = 1'b1;
        pause = 1'b1;
        tick();
        start = 1'b0;
        pause = 1'b0;
        n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL idle_start_wins: state %0d want 1", state); end
        tick();
        n_cmp++; if (Black !== 1'b0) begin n_fail++; $display("FAIL run_black: got %b want 0", Black); end
    endtask

    task automatic test_first_step();
        logic s;
        frames(7);
        probe(41, 30, s);
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL early_step: cell(41,30)=%b want 0", s); end
        probe(40, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL init_head: cell(40,30)=%b want 1", s); end
        frames(1);
        hcount = 11'd328;
        vcount = 11'd240;
        tick();
        n_cmp++; if (Snake !== 1'b1) begin n_fail++; $display("FAIL step_head: pixel(328,240)=%b want 1", Snake); end
        probe(37, 30, s);
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL old_tail: cell(37,30)=%b want 0", s); end
        probe(38, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL new_tail: cell(38,30)=%b want 1", s); end
        n_cmp++; if (length !== 5'd4) begin n_fail++; $display("FAIL idle_grow_ignored: length %0d want 4", length); end
        hcount = 11'd1344;
        vcount = 11'd240;
        tick();
        n_cmp++; if (Snake !== 1'b0) begin n_fail++; $display("FAIL invisible_h: Snake=%b want 0", Snake); end
        hcount = 11'd324;
        vcount = 11'd752;
        tick();
        n_cmp++; if (Snake !== 1'b0) begin n_fail++; $display("FAIL invisible_v: Snake=%b want 0", Snake); end
    endtask

    task automatic test_dir();
        logic s;
        send_dir(2'd3);
        frames(8);
        probe(42, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL reverse_ignored: cell(42,30)=%b want 1", s); end
        send_dir(2'd0);
        send_dir(2'd2);
        frames(8);
        probe(42, 29, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL turn_up: cell(42,29)=%b want 1", s); end
        probe(43, 30, s);
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL turn_up_right: cell(43,30)=%b want 0", s); end
    endtask

    task automatic test_collision();
        logic s;
        send_dir(2'd1);
        pulse_grow();
        frames(8);
        n_cmp++; if (length !== 5'd5) begin n_fail++; $display("FAIL grow_once: length %0d want 5", length); end
        probe(43, 29, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL grow_head: cell(43,29)=%b want 1", s); end
        send_dir(2'd2);
        frames(8);
        probe(43, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL turn_down: cell(43,30)=%b want 1", s); end
        send_dir(2'd3);
        frames(8);
        n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL self_hit: state %0d want 3", state); end
        probe(41, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL stop_frozen_tail: cell(41,30)=%b want 1", s); end
        probe(43, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL stop_frozen_head: cell(43,30)=%b want 1", s); end
        n_cmp++; if (length !== 5'd5) begin n_fail++; $display("FAIL stop_length: length %0d want 5", length); end
        frames(8);
        n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL stop_hold: state %0d want 3", state); end
        n_cmp++; if (Black !== 1'b0) begin n_fail++; $display("FAIL stop_black: got %b want 0", Black); end
    endtask

    task automatic test_pause();
        logic s;
        pulse_start();
        n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL restart_state: state %0d want 1", state); end
        n_cmp++; if (length !== 5'd4) begin n_fail++; $display("FAIL restart_length: length %0d want 4", length); end
        probe(40, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL restart_head: cell(40,30)=%b want 1", s); end
        probe(43, 30, s);
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL restart_clear: cell(43,30)=%b want 0", s); end
        frames(3);
        start = 1'b1;
        pause = 1'b1;
        tick();
        start = 1'b0;
        pause = 1'b0;
        n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL run_pause_wins: state %0d want 2", state); end
        frames(20);
        probe(41, 30, s);
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL pause_frozen: cell(41,30)=%b want 0", s); end
        pulse_pause();
        n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL resume: state %0d want 1", state); end
        frames(4);
        probe(41, 30, s);
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL resume_count: cell(41,30)=%b want 0", s); end
        frames(1);
        probe(41, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL resume_step: cell(41,30)=%b want 1", s); end
    endtask

    task automatic test_grow_sat();
        logic s;
        for (int k = 1; k <= 14; k++) begin
            pulse_grow();
            frames(8);
            if (k == 11) begin
                n_cmp++; if (length !== 5'd15) begin n_fail++; $display("FAIL grow_15: length %0d want 15", length); end
            end
            if (k == 12) begin
                n_cmp++; if (length !== 5'd16) begin n_fail++; $display("FAIL grow_16: length %0d want 16", length); end
            end
        end
        n_cmp++; if (length !== 5'd16) begin n_fail++; $display("FAIL grow_sat: length %0d want 16", length); end
        probe(40, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL sat_tail: cell(40,30)=%b want 1", s); end
        probe(39, 30, s);
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL sat_past_tail: cell(39,30)=%b want 0", s); end
        probe(55, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL sat_head: cell(55,30)=%b want 1", s); end
    endtask

    task automatic test_edge();
        logic s;
        frames(8 * 24);
        probe(79, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL at_edge: cell(79,30)=%b want 1", s); end
        frames(8);
`ifdef SNAKE_WRAP_EN
        n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL wrap_state: state %0d want 1", state); end
        probe(0, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL wrap_head: cell(0,30)=%b want 1", s); end
`else
        n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL wall_state: state %0d want 3", state); end
        probe(0, 30, s);
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL wall_no_wrap: cell(0,30)=%b want 0", s); end
        probe(79, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL wall_frozen: cell(79,30)=%b want 1", s); end
`endif
    endtask

    task automatic test_restart();
        logic s;
        pulse_start();
        n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL restart2_state: state %0d want 1", state); end
        n_cmp++; if (length !== 5'd4) begin n_fail++; $display("FAIL restart2_length: length %0d want 4", length); end
        probe(40, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL restart2_head: cell(40,30)=%b want 1", s); end
        probe(79, 30, s);
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL restart2_old: cell(79,30)=%b want 0", s); end
    endtask

    task automatic test_reset_priority();
        logic s;
        frames(7);
        rst = 1'b1;
        frame_start = 1'b1;
        start = 1'b1;
        pause = 1'b1;
        grow = 1'b1;
        tick();
        rst = 1'b0;
        frame_start = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        grow = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_prio_state: state %0d want 0", state); end
        n_cmp++; if (Black !== 1'b1) begin n_fail++; $display("FAIL rst_prio_black: got %b want 1", Black); end
        probe(40, 30, s);
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL rst_prio_snake: got %b want 0", s); end
        pulse_start();
        frames(1);
        probe(41, 30, s);
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL rst_prio_counter: cell(41,30)=%b want 0", s); end
        frames(7);
        probe(41, 30, s);
        n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL rst_prio_step: cell(41,30)=%b want 1", s); end
        n_cmp++; if (length !== 5'd4) begin n_fail++; $display("FAIL rst_prio_grow: length %0d want 4", length); end
    endtask

    initial begin
        test_reset();
        test_idle_ignores();
        test_first_step();
        test_dir();
        test_collision();
        test_pause();
        test_grow_sat();
        test_edge();
        test_restart();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning segment buffer depth (max snake length).
REQ-002 SHALL have parameter INIT_LEN, default 4, meaning length after reset/restart (2..MAX_LEN).
REQ-003 SHALL have parameter MOVE_DIV, default 8, meaning frames per snake step.
REQ-004 SHALL have ports: clk25MHz  in  1  pixel clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: hcount  in  11  current pixel column; vcount  in  11  current pixel row.
REQ-006 SHALL have ports: frame_start  in  1  one-cycle pulse at (hcount,vcount)=(0,0).
REQ-007 SHALL have ports: dir_req  in  2  requested direction (0 up, 1 right, 2 down, 3 left); dir_valid  in  1  qualifies dir_req.
REQ-008 SHALL have ports: start  in  1  start/restart pulse; pause  in  1  pause-toggle pulse; grow  in  1  lengthen request pulse.
REQ-009 SHALL have ports: Snake  out  1  pixel is snake body; Black  out  1  blank screen.
REQ-010 SHALL have ports: state  out  2  game state; length  out  5  current segment count.
REQ-011 Clocking SHALL be a single clock (clk25MHz); reset rst SHALL be synchronous and active-high.

Function
REQ-012 Grid SHALL be 80x60 cells of 8x8 pixels; cell = (hcount[9:3], vcount[8:3]).
REQ-013 States SHALL be IDLE(0), RUN(1), PAUSE(2), STOP(3).
REQ-014 IDLE: start -> RUN next cycle; pause, grow, dir_valid ignored.
REQ-015 RUN: frame counter increments on frame_start; when frame_start arrives with counter = MOVE_DIV-1, a step SHALL occur that cycle and the counter SHALL clear.
REQ-016 RUN: pause -> PAUSE; PAUSE: pause -> RUN; counter frozen in PAUSE; start ignored in RUN/PAUSE.
REQ-017 Step: head moves one cell in cur_dir; each segment takes predecessor position; cur_dir <= pending_dir before the move is computed.
REQ-018 dir_valid with dir_req equal to the opposite of pending_dir SHALL be ignored; otherwise pending_dir <= dir_req; last accepted request before a step wins.
REQ-019 grow pulse SHALL set a grow flag; the next step SHALL keep the tail (length+1), saturating at MAX_LEN, then clear the flag.
REQ-020 Self-collision: new head equal to any occupied segment except the tail (tail included when growing) -> STOP, body not updated.
REQ-021 STOP: body frozen and displayed; start -> reinitialise body (REQ-025) and enter RUN next cycle.
REQ-022 Snake SHALL be registered (latency 1 cycle from hcount/vcount): 1 iff pixel in visible area (hcount<640, vcount<480) and its cell matches one of the first length segments; 0 in IDLE.
REQ-023 Black SHALL be registered: 1 in IDLE, else 0.
REQ-024 start and pause in the same cycle: start wins in IDLE/STOP; pause wins in RUN/PAUSE.

Reset
REQ-025 rst SHALL force: state IDLE, Snake 0, Black 1, length INIT_LEN, cur_dir = pending_dir = right, counter 0, grow flag 0, segment i at cell (40-i, 30).
REQ-026 rst mid-step or mid-frame SHALL take priority over every other input that cycle.

Configuration
REQ-027 Macro SNAKE_WRAP_EN defined: head leaving grid SHALL wrap (x 79->0, 0->79; y 59->0, 0->59).
REQ-028 SNAKE_WRAP_EN undefined: step that would leave grid SHALL enter STOP with body unchanged.

Structure
REQ-029 Shared package snake_pkg SHALL hold direction and state encodings, GRID_W=80, GRID_H=60, CELL_SHIFT=3.
REQ-030 Sub-module snake_body_buf SHALL hold the segment shift buffer and the pixel/head hit comparators; FSM, divider and direction logic in snake_game_ctrl.

Verification
REQ-031 Reset, then scan frame -> Black=1, Snake=0 everywhere; length=4, state=0.
REQ-032 start, MOVE_DIV=8, 8 frame_start pulses -> exactly one step, head at (41,30), pixel (328,240) gives Snake=1 one cycle later.
REQ-033 cur_dir right, dir_req=left valid -> ignored; dir_req=up then down before step -> up taken, head y-1.
REQ-034 grow at MAX_LEN-1 then two more grows -> length reaches 16 and holds.
REQ-035 Head at (79,30) moving right -> STOP without SNAKE_WRAP_EN; head at (0,30) with it; start from STOP -> reset body, RUN.
REQ-036 Length 5, turns up/left/down in consecutive steps -> head hits body, state=3; pause while RUN -> counter frozen, no step for 20 frames.
